// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the March C-style RAM BIST controller.
// RAM_BIST_DUAL_PORT_EN selects the two-pass (role-swapped) variant.
package ram_bist_pkg;

    typedef enum logic [3:0] {
        IDLE,
        M0_WR,
        M1_RD,
        M1_WR,
        M2_RD,
        M2_WR,
        M3_RD,
        M3_CHK,
        FIN
    } bist_state_t;

    // Wide backgrounds; users slice down to their data width.
    localparam logic [63:0] BG0 = '0;
    localparam logic [63:0] BG1 = '1;

    function automatic int unsigned pass_cycles(input int unsigned addr_w);
        return 7 * (1 << addr_w);
    endfunction

    localparam int unsigned PASS_CYCLES = pass_cycles(3);

`ifdef RAM_BIST_DUAL_PORT_EN
    localparam int unsigned NUM_PASSES = 2;
`else
    localparam int unsigned NUM_PASSES = 1;
`endif

endpackage

// File: rtl/ram_bist_cmp.sv
// Registered comparator that captures address and data of the first miscompare.
// Later miscompares leave the captured values untouched.
module ram_bist_cmp
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] expected,
    input  logic [DATA_W-1:0] actual,
    input  logic [ADDR_W-1:0] addr,
    output logic              fail_seen,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            fail_seen <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (en && (actual != expected) && !fail_seen) begin
            fail_seen <= 1'b1;
            fail_addr <= addr;
            fail_data <= actual;
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// March C-style BIST controller for the dual-port RAM: FSM, address counter, port muxing.
// Define RAM_BIST_DUAL_PORT_EN for a second pass with write/read ports swapped.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] data_in_a,
    output logic              we_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] data_in_b,
    output logic              we_b,
    input  logic [DATA_W-1:0] data_out_a,
    input  logic [DATA_W-1:0] data_out_b
);

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    localparam logic [DATA_W-1:0] BG0_W   = BG0[DATA_W-1:0];
    localparam logic [DATA_W-1:0] BG1_W   = BG1[DATA_W-1:0];

    bist_state_t       state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic              swap, swap_nxt;
    logic              pass_q;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              cmp_en;
    logic [DATA_W-1:0] cmp_exp;
    logic [DATA_W-1:0] rd_data;
    logic              cmp_clear;
    logic              fail_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            swap  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            swap  <= swap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        swap_nxt  = swap;
        wr_en     = 1'b0;
        wr_data   = '0;
        cmp_en    = 1'b0;
        cmp_exp   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = M0_WR;
                    ptr_nxt   = '0;
                    swap_nxt  = 1'b0;
                end
            end
            M0_WR: begin
                wr_en   = 1'b1;
                wr_data = BG0_W;
                if (ptr == PTR_MAX) begin
                    state_nxt = M1_RD;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            M1_RD: state_nxt = M1_WR;
            M1_WR: begin
                cmp_en  = 1'b1;
                cmp_exp = BG0_W;
                wr_en   = 1'b1;
                wr_data = BG1_W;
                if (ptr == PTR_MAX) begin
                    state_nxt = M2_RD;
                end else begin
                    state_nxt = M1_RD;
                    ptr_nxt   = ptr + 1'b1;
                end
            end
            M2_RD: state_nxt = M2_WR;
            M2_WR: begin
                cmp_en  = 1'b1;
                cmp_exp = BG1_W;
                wr_en   = 1'b1;
                wr_data = BG0_W;
                if (ptr == '0) begin
                    state_nxt = M3_RD;
                end else begin
                    state_nxt = M2_RD;
                    ptr_nxt   = ptr - 1'b1;
                end
            end
            M3_RD: state_nxt = M3_CHK;
            M3_CHK: begin
                cmp_en  = 1'b1;
                cmp_exp = BG0_W;
                if (ptr == PTR_MAX) begin
`ifdef RAM_BIST_DUAL_PORT_EN
                    if (!swap) begin
                        state_nxt = M0_WR;
                        ptr_nxt   = '0;
                        swap_nxt  = 1'b1;
                    end else begin
                        state_nxt = FIN;
                    end
`else
                    state_nxt = FIN;
`endif
                end else begin
                    state_nxt = M3_RD;
                    ptr_nxt   = ptr + 1'b1;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE) && (state != FIN);
    assign done      = (state == FIN);
    assign cmp_clear = (state == IDLE) && start;

    // swap selects which port writes and which reads back; it stays 0 in single-pass builds.
    assign rd_data   = swap ? data_out_a : data_out_b;
    assign addr_a    = busy ? ptr : '0;
    assign addr_b    = busy ? ptr : '0;
    assign we_a      = wr_en && !swap;
    assign data_in_a = swap ? '0 : wr_data;
`ifdef RAM_BIST_DUAL_PORT_EN
    assign we_b      = wr_en && swap;
    assign data_in_b = swap ? wr_data : '0;
`else
    assign we_b      = 1'b0;
    assign data_in_b = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst || cmp_clear) begin
            pass_q <= 1'b0;
        end else if (state == FIN) begin
            pass_q <= !fail_seen;
        end
    end

    // Final compare registers on the edge into FIN, so the verdict is visible during the done pulse.
    assign pass = (state == FIN) ? !fail_seen : pass_q;

    ram_bist_cmp #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_cmp (
        .clk      (clk),
        .rst      (rst),
        .clear    (cmp_clear),
        .en       (cmp_en),
        .expected (cmp_exp),
        .actual   (rd_data),
        .addr     (ptr),
        .fail_seen(fail_seen),
        .fail_addr(fail_addr),
        .fail_data(fail_data)
    );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl: faulty RAM model, abstract March model, per-cycle compare.
module tb_ram_bist_ctrl;
    import ram_bist_pkg::*;

    localparam int D = 8;
`ifdef RAM_BIST_DUAL_PORT_EN
    localparam int NP = 2;
`else
    localparam int NP = 1;
`endif
    localparam int PC    = 7 * D;
    localparam int TOTAL = PC * NP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [2:0] fail_addr;
    logic [7:0] fail_data;
    logic [2:0] addr_a, addr_b;
    logic [7:0] data_in_a, data_in_b;
    logic       we_a, we_b;
    logic [7:0] data_out_a, data_out_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_bist_ctrl #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_data(fail_data),
        .addr_a(addr_a), .data_in_a(data_in_a), .we_a(we_a),
        .addr_b(addr_b), .data_in_b(data_in_b), .we_b(we_b),
        .data_out_a(data_out_a), .data_out_b(data_out_b)
    );

    // Fault modes: 0 none, 1 addr 5 bit 3 stuck-at-1, 2 addr 6 aliased onto 2, 3 port A out bit 0 stuck-at-0
    int         fault_mode = 0;
    logic [7:0] mem [D];

    function automatic int phys(input int a);
        return (fault_mode == 2 && a == 6) ? 2 : a;
    endfunction

    function automatic logic [7:0] faulty(input int p, input logic [7:0] v, input bit port_a);
        logic [7:0] r;
        r = v;
        if (fault_mode == 1 && p == 5) r = r | 8'h08;
        if (fault_mode == 3 && port_a) r = r & 8'hFE;
        return r;
    endfunction

    always @(posedge clk) begin
        if (we_a) mem[phys(int'(addr_a))] <= data_in_a;
        else data_out_a <= faulty(phys(int'(addr_a)), mem[phys(int'(addr_a))], 1'b1);
        if (we_b) mem[phys(int'(addr_b))] <= data_in_b;
        else data_out_b <= faulty(phys(int'(addr_b)), mem[phys(int'(addr_b))], 1'b0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract March model: whole-array element sweeps, first miscompare wins.
    logic [7:0] sm [D];
    bit         exp_fail;
    logic [2:0] exp_fa;
    logic [7:0] exp_fd;

    task automatic sim_read(input int a, input logic [7:0] e, input bit port_a);
        logic [7:0] v;
        v = faulty(phys(a), sm[phys(a)], port_a);
        if (v != e && !exp_fail) begin
            exp_fail = 1'b1;
            exp_fa   = 3'(a);
            exp_fd   = v;
        end
    endtask

    task automatic compute_expect();
        bit rd_a;
        exp_fail = 1'b0; exp_fa = '0; exp_fd = '0;
        for (int p = 0; p < NP; p++) begin
            rd_a = (p == 1);
            for (int a = 0; a < D; a++) sm[phys(a)] = 8'h00;
            for (int a = 0; a < D; a++) begin sim_read(a, 8'h00, rd_a); sm[phys(a)] = 8'hFF; end
            for (int a = D - 1; a >= 0; a--) begin sim_read(a, 8'hFF, rd_a); sm[phys(a)] = 8'h00; end
            for (int a = 0; a < D; a++) sim_read(a, 8'h00, rd_a);
        end
    endtask

    // Run-tracking model: start accepted only when idle; reset abandons the run.
    bit         act = 1'b0;
    bit         res_valid = 1'b0;
    int         cyc = 0;
    bit         held_pass;
    logic [2:0] held_fa;
    logic [7:0] held_fd;
    bit         mon_en = 1'b0;
    int         n_done = 0;

    always @(posedge clk) begin
        if (rst) begin
            act <= 1'b0; res_valid <= 1'b0;
        end else if (!act) begin
            if (start) begin act <= 1'b1; cyc <= 0; res_valid <= 1'b0; end
        end else if (cyc == TOTAL) begin
            act <= 1'b0; res_valid <= 1'b1;
            held_pass <= !exp_fail; held_fa <= exp_fa; held_fd <= exp_fd;
        end else begin
            cyc <= cyc + 1;
        end
    end

    int         m_p, m_t, m_t2, m_e, m_k, m_a, m_kind;
    logic [7:0] m_d;
    logic       w_we, r_we;
    logic [2:0] w_addr, r_addr;
    logic [7:0] w_din;

    always @(negedge clk) begin
        if (mon_en) begin
            if (done) n_done++;
`ifndef RAM_BIST_DUAL_PORT_EN
            chk("we_b_tied", 32'(we_b), 0);
            chk("data_in_b_tied", 32'(data_in_b), 0);
`endif
            if (act) begin
                chk("busy", 32'(busy), 32'(cyc < TOTAL));
                chk("done", 32'(done), 32'(cyc == TOTAL));
                if (cyc < TOTAL) begin
                    chk("pass_cleared", 32'(pass), 0);
                    m_p = cyc / PC; m_t = cyc % PC; m_d = 8'h00;
                    if (m_t < D) begin
                        m_kind = 0; m_a = m_t;
                    end else begin
                        m_t2 = m_t - D;
                        m_e  = m_t2 / (2 * D) + 1;
                        m_k  = (m_t2 % (2 * D)) / 2;
                        m_a  = (m_e == 2) ? D - 1 - m_k : m_k;
                        m_kind = (m_t2 % 2 == 0) ? 1 : ((m_e == 3) ? 2 : 0);
                        m_d  = (m_e == 1) ? 8'hFF : 8'h00;
                    end
                    w_we = (m_p == 0) ? we_a : we_b;  r_we = (m_p == 0) ? we_b : we_a;
                    w_addr = (m_p == 0) ? addr_a : addr_b;  r_addr = (m_p == 0) ? addr_b : addr_a;
                    w_din = (m_p == 0) ? data_in_a : data_in_b;
                    chk("read_port_we", 32'(r_we), 0);
                    if (m_kind == 0) begin
                        chk("wr_we", 32'(w_we), 1);
                        chk("wr_addr", 32'(w_addr), 32'(m_a));
                        chk("wr_data", 32'(w_din), 32'(m_d));
                    end else begin
                        chk("rd_no_write", 32'(w_we), 0);
                        if (m_kind == 1) chk("rd_addr", 32'(r_addr), 32'(m_a));
                    end
                end else begin
                    chk("pass_at_done", 32'(pass), 32'(!exp_fail));
                    chk("fail_addr_at_done", 32'(fail_addr), 32'(exp_fa));
                    chk("fail_data_at_done", 32'(fail_data), 32'(exp_fd));
                end
            end else begin
                chk("idle_busy", 32'(busy), 0);
                chk("idle_done", 32'(done), 0);
                chk("idle_we", 32'({we_a, we_b}), 0);
                chk("idle_addr", 32'({addr_a, addr_b}), 0);
                chk("idle_din", 32'({data_in_a, data_in_b}), 0);
                chk("idle_pass", 32'(pass), res_valid ? 32'(held_pass) : 0);
                chk("idle_fail_addr", 32'(fail_addr), res_valid ? 32'(held_fa) : 0);
                chk("idle_fail_data", 32'(fail_data), res_valid ? 32'(held_fd) : 0);
            end
        end
    end

    task automatic run_test(input int mode, input int repulse_at, input int rst_at, input int want_done);
        fault_mode = mode;
        compute_expect();
        @(negedge clk); n_done = 0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < TOTAL + 10; i++) begin
            @(negedge clk);
            start = (act && cyc == repulse_at);
            rst   = (act && cyc == rst_at);
        end
        start = 1'b0; rst = 1'b0;
        chk("done_count", 32'(n_done), 32'(want_done));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_fail_addr", 32'(fail_addr), 0);
        rst = 1'b0;

        run_test(0, -1, -1, 1);
        chk("clean_pass", 32'(pass), 1);
        chk("clean_fail_addr", 32'(fail_addr), 0);

        run_test(1, -1, -1, 1);
        chk("model_stuck_fa", 32'(exp_fa), 5);
        chk("stuck_pass", 32'(pass), 0);
        chk("stuck_fail_addr", 32'(fail_addr), 32'h5);
        chk("stuck_fail_data", 32'(fail_data), 32'h08);

        run_test(2, -1, -1, 1);
        chk("alias_pass", 32'(pass), 0);
        chk("alias_fail_addr", 32'(fail_addr), 6);
        chk("alias_fail_data", 32'(fail_data), 32'hFF);

        run_test(0, -1, 20, 0);
        chk("after_rst_pass", 32'(pass), 0);
        run_test(0, -1, -1, 1);
        chk("post_rst_clean_pass", 32'(pass), 1);

        run_test(0, 10, -1, 1);
        chk("repulse_pass", 32'(pass), 1);

        run_test(3, -1, -1, 1);
`ifdef RAM_BIST_DUAL_PORT_EN
        chk("portA_pass", 32'(pass), 0);
        chk("portA_fail_data_bit0", 32'(fail_data[0]), 0);
        chk("portA_fail_addr", 32'(fail_addr), 7);
        chk("portA_fail_data", 32'(fail_data), 32'hFE);
`else
        chk("portA_unused_pass", 32'(pass), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
